// File: rtl/gb_cart_bus_master.sv
// Game Boy cartridge bus initiator: turns single-beat valid/ready requests
// into timed cartridge cycles (SETUP -> STROBE -> HOLD) with registered
// address, data, output enable, nRD, nWR and external-RAM chip select.
module gb_cart_bus_master #(
  parameter int unsigned SETUP_CYC  = 2,
  parameter int unsigned STROBE_CYC = 4,
  parameter int unsigned HOLD_CYC   = 2
) (
  input  logic        sys_clock,
  input  logic        sys_resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic [15:0] Cart_a,
  output logic [7:0]  Cart_d_out,
  output logic        Cart_d_oe,
  input  logic [7:0]  Cart_d_in,
  output logic        Cart_nRD,
  output logic        Cart_nWR,
  output logic        Cart_nCS
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  localparam logic [7:0] SETUP_LOAD  = 8'(SETUP_CYC - 1);
  localparam logic [7:0] STROBE_LOAD = 8'(STROBE_CYC - 1);
  localparam logic [7:0] HOLD_LOAD   = 8'(HOLD_CYC - 1);

  // External RAM window A000..FDFF selects the cartridge chip.
  function automatic logic ram_select(input logic [15:0] a);
    return (a[15:13] inside {3'b101, 3'b110, 3'b111}) && (a < 16'hFE00);
  endfunction

  state_t      state_r, state_s;
  logic [7:0]  count_r, count_s;
  logic        write_r, write_s;
  logic [15:0] cart_a_s;
  logic [7:0]  d_out_s;
  logic        d_oe_s;
  logic        nrd_s;
  logic        nwr_s;
  logic        ncs_s;
  logic        rsp_valid_s;
  logic [7:0]  rsp_rdata_s;
  logic        req_ready_s;

  // Next-state and next-output decode; outputs are registered below.
  always_comb begin
    state_s     = state_r;
    count_s     = count_r;
    write_s     = write_r;
    cart_a_s    = Cart_a;
    d_out_s     = Cart_d_out;
    d_oe_s      = Cart_d_oe;
    nrd_s       = 1'b1;
    nwr_s       = 1'b1;
    ncs_s       = Cart_nCS;
    rsp_valid_s = 1'b0;
    rsp_rdata_s = rsp_rdata;
    req_ready_s = req_ready;
    case (state_r)
      IDLE: begin
        if (req_valid && req_ready) begin
          state_s     = SETUP;
          count_s     = SETUP_LOAD;
          write_s     = req_write;
          cart_a_s    = req_addr;
          d_out_s     = req_write ? req_wdata : Cart_d_out;
          d_oe_s      = req_write;
          ncs_s       = ~ram_select(req_addr);
          req_ready_s = 1'b0;
        end else begin
          d_oe_s      = 1'b0;
          ncs_s       = 1'b1;
          req_ready_s = 1'b1;
        end
      end
      SETUP: begin
        if (count_r == 8'd0) begin
          state_s = STROBE;
          count_s = STROBE_LOAD;
          nrd_s   = write_r;
          nwr_s   = ~write_r;
        end else begin
          count_s = count_r - 8'd1;
        end
      end
      STROBE: begin
        if (count_r == 8'd0) begin
          state_s     = HOLD;
          count_s     = HOLD_LOAD;
          rsp_valid_s = 1'b1;
          if (!write_r) begin
            rsp_rdata_s = Cart_d_in;
          end else begin
            rsp_rdata_s = rsp_rdata;
          end
        end else begin
          count_s = count_r - 8'd1;
          nrd_s   = Cart_nRD;
          nwr_s   = Cart_nWR;
        end
      end
      HOLD: begin
        if (count_r == 8'd0) begin
          state_s     = IDLE;
          d_oe_s      = 1'b0;
          ncs_s       = 1'b1;
          req_ready_s = 1'b1;
        end else begin
          count_s = count_r - 8'd1;
        end
      end
      default: begin
        state_s     = IDLE;
        count_s     = 8'd0;
        d_oe_s      = 1'b0;
        ncs_s       = 1'b1;
        req_ready_s = 1'b1;
      end
    endcase
  end

  // State, counter and registered bus outputs; reset drops any transaction.
  always_ff @(posedge sys_clock or negedge sys_resetn) begin
    if (!sys_resetn) begin
      state_r    <= IDLE;
      count_r    <= 8'd0;
      write_r    <= 1'b0;
      Cart_a     <= 16'h0000;
      Cart_d_out <= 8'h00;
      Cart_d_oe  <= 1'b0;
      Cart_nRD   <= 1'b1;
      Cart_nWR   <= 1'b1;
      Cart_nCS   <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= 8'h00;
      req_ready  <= 1'b1;
    end else begin
      state_r    <= state_s;
      count_r    <= count_s;
      write_r    <= write_s;
      Cart_a     <= cart_a_s;
      Cart_d_out <= d_out_s;
      Cart_d_oe  <= d_oe_s;
      Cart_nRD   <= nrd_s;
      Cart_nWR   <= nwr_s;
      Cart_nCS   <= ncs_s;
      rsp_valid  <= rsp_valid_s;
      rsp_rdata  <= rsp_rdata_s;
      req_ready  <= req_ready_s;
    end
  end

endmodule

// File: tb/tb_gb_cart_bus_master.sv
// Directed bench for gb_cart_bus_master: default timing instance plus a
// 1/1/1 timing instance, with a ROM-mapper bank register and a read responder.
module tb_gb_cart_bus_master;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req_valid = 1'b0, req_write = 1'b0;
  logic [15:0] req_addr = 16'h0000;
  logic [7:0]  req_wdata = 8'h00;
  logic        req_ready, rsp_valid;
  logic [7:0]  rsp_rdata;
  logic [15:0] cart_a;
  logic [7:0]  cart_d_out, cart_d_in;
  logic        cart_d_oe, cart_nrd, cart_nwr, cart_ncs;
  logic [7:0]  resp_byte = 8'h00;
  logic [4:0]  bank = 5'd1;

  logic        f_valid = 1'b0, f_write = 1'b0;
  logic [15:0] f_addr = 16'h0000;
  logic [7:0]  f_wdata = 8'h00;
  logic        f_ready, f_rsp_valid;
  logic [7:0]  f_rdata;
  logic [15:0] f_a;
  logic [7:0]  f_d_out, f_d_in;
  logic        f_oe, f_nrd, f_nwr, f_ncs;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign cart_d_in = !cart_nrd ? resp_byte : 8'h00;
  assign f_d_in    = !f_nrd ? 8'h5A : 8'h00;

  // ROM mapper model: a write into 2000..3FFF selects the ROM bank.
  always @(posedge cart_nwr) begin
    if (rstn && cart_a[15:13] == 3'b001) bank <= cart_d_out[4:0];
  end

  gb_cart_bus_master dut (
    .sys_clock(clk), .sys_resetn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .Cart_a(cart_a), .Cart_d_out(cart_d_out), .Cart_d_oe(cart_d_oe),
    .Cart_d_in(cart_d_in), .Cart_nRD(cart_nrd), .Cart_nWR(cart_nwr),
    .Cart_nCS(cart_ncs)
  );

  gb_cart_bus_master #(.SETUP_CYC(1), .STROBE_CYC(1), .HOLD_CYC(1)) u_fast (
    .sys_clock(clk), .sys_resetn(rstn),
    .req_valid(f_valid), .req_ready(f_ready), .req_write(f_write),
    .req_addr(f_addr), .req_wdata(f_wdata),
    .rsp_valid(f_rsp_valid), .rsp_rdata(f_rdata),
    .Cart_a(f_a), .Cart_d_out(f_d_out), .Cart_d_oe(f_oe),
    .Cart_d_in(f_d_in), .Cart_nRD(f_nrd), .Cart_nWR(f_nwr),
    .Cart_nCS(f_ncs)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One transaction on the default instance; profiles the cycles after accept.
  task automatic run_txn(input logic wr, input logic [15:0] addr, input logic [7:0] wd,
                         output int n_wr, output int n_rd, output int n_oe, output int n_ncs,
                         output int n_busy, output int rsp_cyc, output int n_rsp,
                         output logic [7:0] rd, output logic dout_ok, output int n_both);
    n_wr = 0; n_rd = 0; n_oe = 0; n_ncs = 0; n_busy = 0; rsp_cyc = 0; n_rsp = 0;
    rd = 8'h00; dout_ok = 1'b1; n_both = 0;
    @(negedge clk);
    check("ready_before_req", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0; req_addr = 16'h0000; req_wdata = 8'h00;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (req_ready) break;
      n_busy++;
      if (!cart_nwr) n_wr++;
      if (!cart_nrd) n_rd++;
      if (!cart_nwr && !cart_nrd) n_both++;
      if (!cart_ncs) n_ncs++;
      if (cart_d_oe) begin
        n_oe++;
        if (cart_d_out !== wd) dout_ok = 1'b0;
      end
      if (rsp_valid) begin
        n_rsp++; rsp_cyc = c; rd = rsp_rdata;
      end
    end
  endtask

  initial begin
    int n_wr, n_rd, n_oe, n_ncs, n_busy, rsp_cyc, n_rsp, n_both;
    logic [7:0] rd;
    logic dout_ok;
    logic [15:0] dec_addr [4];
    int dec_exp [4];
    int acc, busy, nr, nw;
    int acc_t [3];
    logic [7:0] frd;

    // Reset values
    #12;
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    check("rst_bus", {cart_a, cart_d_out, 3'd0, cart_d_oe, cart_nrd, cart_nwr, cart_ncs, rsp_valid},
          {16'h0000, 8'h00, 3'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0});
    check("rst_rdata", {24'd0, rsp_rdata}, 32'd0);
    @(negedge clk); rstn = 1'b1;

    // Bank-select write
    run_txn(1'b1, 16'h2000, 8'h05, n_wr, n_rd, n_oe, n_ncs, n_busy, rsp_cyc, n_rsp, rd, dout_ok, n_both);
    check("wr_nwr_low", n_wr, 4);
    check("wr_nrd_low", n_rd, 0);
    check("wr_oe_cycles", n_oe, 8);
    check("wr_dout", {31'd0, dout_ok}, 32'd1);
    check("wr_ncs", n_ncs, 0);
    check("wr_rsp_count", n_rsp, 1);
    check("wr_rsp_cycle", rsp_cyc, 7);
    check("wr_busy", n_busy, 8);
    check("wr_bank", {27'd0, bank}, 32'd5);
    check("wr_rdata_held", {24'd0, rsp_rdata}, 32'd0);

    // ROM read
    resp_byte = 8'hA5;
    run_txn(1'b0, 16'h4123, 8'h00, n_wr, n_rd, n_oe, n_ncs, n_busy, rsp_cyc, n_rsp, rd, dout_ok, n_both);
    check("rd_nrd_low", n_rd, 4);
    check("rd_nwr_low", n_wr, 0);
    check("rd_oe", n_oe, 0);
    check("rd_ncs", n_ncs, 0);
    check("rd_rsp_count", n_rsp, 1);
    check("rd_rsp_cycle", rsp_cyc, 7);
    check("rd_rdata", {24'd0, rd}, 32'hA5);
    check("rd_addr_held", {16'd0, cart_a}, 32'h4123);

    // Chip select decode
    dec_addr[0] = 16'h7FFF; dec_exp[0] = 0;
    dec_addr[1] = 16'hA010; dec_exp[1] = 8;
    dec_addr[2] = 16'hFDFF; dec_exp[2] = 8;
    dec_addr[3] = 16'hFE00; dec_exp[3] = 0;
    for (int i = 0; i < 4; i++) begin
      resp_byte = 8'h30 + 8'(i);
      run_txn(1'b0, dec_addr[i], 8'h00, n_wr, n_rd, n_oe, n_ncs, n_busy, rsp_cyc, n_rsp, rd, dout_ok, n_both);
      check($sformatf("ncs_%h", dec_addr[i]), n_ncs, dec_exp[i]);
      check($sformatf("ncs_rdata_%h", dec_addr[i]), {24'd0, rd}, {24'd0, 8'h30 + 8'(i)});
    end

    // Write leaves rsp_rdata holding the last read value
    run_txn(1'b1, 16'hA100, 8'h77, n_wr, n_rd, n_oe, n_ncs, n_busy, rsp_cyc, n_rsp, rd, dout_ok, n_both);
    check("ram_wr_ncs", n_ncs, 8);
    check("ram_wr_rdata_held", {24'd0, rsp_rdata}, 32'h33);
    check("ram_wr_no_overlap", n_both, 0);

    // Three queued reads with valid held high
    resp_byte = 8'h11;
    acc = 0; busy = 0; nr = 0;
    req_write = 1'b0; req_addr = 16'h0100;
    @(negedge clk);
    for (int c = 0; c < 60; c++) begin
      if (c > 0) @(negedge clk);
      if (rsp_valid) nr++;
      if (!req_ready) busy++;
      else if (acc < 3) begin
        acc_t[acc] = c; acc++; req_valid = 1'b1;
      end else begin
        req_valid = 1'b0;
        break;
      end
    end
    req_valid = 1'b0;
    check("q_accepts", acc, 3);
    check("q_spacing1", acc_t[1] - acc_t[0], 9);
    check("q_spacing2", acc_t[2] - acc_t[1], 9);
    check("q_busy", busy, 24);
    check("q_rsp", nr, 3);

    // Reset during the second STROBE cycle of a write
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h2000; req_wdata = 8'h07;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_rst_nwr", {31'd0, cart_nwr}, 32'd0);
    rstn = 1'b0; #1;
    check("arst_nwr", {31'd0, cart_nwr}, 32'd1);
    check("arst_oe", {31'd0, cart_d_oe}, 32'd0);
    check("arst_addr", {16'd0, cart_a}, 32'd0);
    check("arst_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk); rstn = 1'b1;
    nr = 0; busy = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (rsp_valid) nr++;
      if (!req_ready) busy++;
    end
    check("arst_no_rsp", nr, 0);
    check("arst_idle", busy, 0);
    check("arst_bank", {27'd0, bank}, 32'd5);
    run_txn(1'b1, 16'h2000, 8'h03, n_wr, n_rd, n_oe, n_ncs, n_busy, rsp_cyc, n_rsp, rd, dout_ok, n_both);
    check("post_rst_rsp", n_rsp, 1);
    check("post_rst_bank", {27'd0, bank}, 32'd3);

    // 1/1/1 timing: write then read back-to-back
    acc = 0; busy = 0; nr = 0; nw = 0; n_rd = 0; frd = 8'h00;
    @(negedge clk);
    for (int c = 0; c < 40; c++) begin
      if (c > 0) @(negedge clk);
      if (!f_nwr) nw++;
      if (!f_nrd) n_rd++;
      if (f_rsp_valid) begin nr++; frd = f_rdata; end
      if (!f_ready) busy++;
      else if (acc < 2) begin
        acc_t[acc] = c;
        f_valid = 1'b1; f_write = (acc == 0); f_addr = 16'hA000; f_wdata = 8'h11;
        acc++;
      end else begin
        f_valid = 1'b0;
        break;
      end
    end
    f_valid = 1'b0;
    check("fast_accepts", acc, 2);
    check("fast_spacing", acc_t[1] - acc_t[0], 4);
    check("fast_busy", busy, 6);
    check("fast_nwr_width", nw, 1);
    check("fast_nrd_width", n_rd, 1);
    check("fast_rsp", nr, 2);
    check("fast_rdata", {24'd0, frd}, 32'h5A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
